// File: rtl/fifo_egress_reader.sv
// Purpose : drains header/LEN/payload packets from the port FIFO onto a valid/ready byte stream with sop/eop.
// Latency : FIFO read at cycle t -> byte presented with out_valid in cycle t+2.
// Backpressure: no new FIFO read while a held byte waits on out_ready; at most one read is ever in flight.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   en                       port enable; only gates reading a new header
//   fifo_empty, fifo_data    FIFO status and registered read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en               combinational FIFO read strobe
//   out_data/out_valid/out_ready, out_sop/out_eop   output byte stream and packet markers
//   busy                     packet in progress (mid-packet, read in flight, or byte held)
//   pkt_cnt                  count of fully delivered packets, wraps
module fifo_egress_reader #(
  parameter int W_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [W_WIDTH-1:0]   fifo_data,
  output logic                 fifo_rd_en,
  output logic [W_WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_cnt
);

  // State names the field type of the next byte to be read from the FIFO.
  typedef enum logic [1:0] {S_HDR, S_LEN, S_PAY} state_t;

  state_t               state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic                 inflight_q, inflight_d;
  logic [W_WIDTH-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  // A read is only issued when the output register will be free by the time
  // the byte lands, so a capture never collides with a held byte.
  assign fifo_rd_en = rst_n && !inflight_q && !fifo_empty &&
                      (!out_valid_q || out_ready) &&
                      ((state_q != S_HDR) || en);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    pkt_cnt_d   = pkt_cnt_q;

    // Set by a read, cleared at the capture edge that follows; a read can
    // never coincide with an in-flight byte, so this is just the strobe.
    inflight_d = fifo_rd_en;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (out_eop_q) begin
        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
      end
    end

    // Capture wins over accept; both on one edge cannot happen, see fifo_rd_en.
    if (inflight_q) begin
      out_data_d  = fifo_data;
      out_valid_d = 1'b1;
      unique case (state_q)
        S_HDR: begin
          out_sop_d = 1'b1;
          out_eop_d = 1'b0;
          state_d   = S_LEN;
        end
        S_LEN: begin
          out_sop_d = 1'b0;
          if (fifo_data[7:0] == 8'd0) begin
            out_eop_d = 1'b1;
            state_d   = S_HDR;
          end else begin
            out_eop_d = 1'b0;
            rem_d     = fifo_data[7:0];
            state_d   = S_PAY;
          end
        end
        S_PAY: begin
          out_sop_d = 1'b0;
          out_eop_d = (rem_q == 8'd1);
          rem_d     = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_HDR;
          end
        end
        default: begin
          state_d = S_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      rem_q       <= 8'd0;
      inflight_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign busy      = (state_q != S_HDR) || inflight_q || out_valid_q;

endmodule

// File: doc/fifo_egress_reader.md
# fifo_egress_reader

Egress stage of a switch output port: drains byte-wide packets from the port's FIFO and presents them on a valid/ready output interface with start-of-packet and end-of-packet markers. It sits directly downstream of the port FIFO.

- FIFO contract: data is registered, appears on fifo_data the cycle after a read with the FIFO non-empty, and is zeroed after that cycle.
- Packet format: header byte, then LEN byte, then LEN payload bytes. Total LEN+2 bytes, LEN 0..255.

## Interface
- W_WIDTH, 8: byte width; must match the FIFO width.
- CNT_WIDTH, 16: width of the delivered-packet counter.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  port enable; gates the start of a new packet only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  W_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe, combinational.
- out_data  out  W_WIDTH  output byte.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready.
- out_sop  out  1  byte is a header; qualified by out_valid.
- out_eop  out  1  byte is the last of its packet; qualified by out_valid.
- busy  out  1  a packet is in progress.
- pkt_cnt  out  CNT_WIDTH  packets fully delivered, wraps.

## Operation
- Field state, meaning the type of the next byte to read: S_HDR, S_LEN, S_PAY. Register `rem` is 8 bits; flag `inflight` marks a read issued but not yet captured.
- fifo_rd_en = rst_n && !inflight && !fifo_empty && (!out_valid || out_ready) && (state != S_HDR || en).
- At most one read is outstanding at any time.
- A read sets `inflight`. On the next edge, fifo_data is captured into out_data, out_valid is set, and `inflight` is cleared.
- State and marker update at the capture edge:
  - S_HDR: out_sop=1, out_eop=0, go to S_LEN.
  - S_LEN: out_sop=0. If the byte is 0: out_eop=1, go to S_HDR. Otherwise: out_eop=0, rem=byte, go to S_PAY.
  - S_PAY: out_eop = (rem==1), rem = rem-1. When rem==1, go to S_HDR.
- The output register holds out_data, out_sop and out_eop stable while out_valid && !out_ready.
- out_valid clears on the accept edge unless a capture occurs on that same edge, which cannot happen because of the single-outstanding-read rule.
- pkt_cnt increments on every accept with out_eop=1; it wraps from 2^CNT_WIDTH-1 to 0.
- busy = (state != S_HDR) || inflight || out_valid.
- en low mid-packet: the current packet completes; no new header is read until en=1.
- FIFO empty mid-packet: reading stalls and resumes when fifo_empty drops. No timeout, no error.
- Reset, any time: asynchronously forces the outputs below. A partially sent packet is abandoned. The FIFO shares rst_n.
  - fifo_rd_en=0, out_data=0, out_valid=0, out_sop=0, out_eop=0.
  - busy=0, pkt_cnt=0, state=S_HDR, rem=0, inflight=0.

## Timing
- Read at cycle t: out_valid=1 with that byte in cycle t+1+1 = t+2.
- Latency from fifo_empty falling (FIFO idle, en=1, output free) to the first out_valid: 2 cycles.
- fifo_rd_en may assert in the same cycle the current byte is accepted (out_valid && out_ready).
- Peak throughput with out_ready held at 1: one byte every 2 cycles. A packet of LEN bytes occupies 2*(LEN+2) cycles.
- out_ready low: no new read is issued while out_valid=1. At most the one in-flight byte is captured, into an empty register.
- out_ready may toggle freely; there are no combinational paths from out_ready to out_valid, out_data or the markers.

## Test plan
- Reset values: hold rst_n=0 with fifo_empty=0 and en=1 -> all outputs 0 and fifo_rd_en=0. Release rst_n -> first fifo_rd_en occurs on the first cycle after release.
- Single packet 0x03,0x02,0xAA,0xBB with out_ready=1:
  - output bytes 03,02,AA,BB at 2-cycle spacing;
  - sop on 03 only, eop on BB only;
  - pkt_cnt 0->1 on BB accept; busy falls the cycle after.
- LEN=0 packet 0x05,0x00 followed by packet 0x06,0x01,0x77:
  - eop on 00, sop on 06, eop on 77;
  - pkt_cnt=2; no byte dropped or duplicated.
- Backpressure: out_ready=0 for 10 cycles mid-payload -> out_data, out_sop and out_eop are stable, fifo_rd_en=0 throughout, and the stream resumes in order.
- en=0 asserted during payload -> the packet finishes; no read of the next header until en=1, then the next header is delivered with sop.
- FIFO underrun mid-packet (fifo_empty=1 for 5 cycles), then a mid-packet rst_n pulse -> the stream stalls then resumes. After reset: state=S_HDR, pkt_cnt=0, and the next byte read is treated as a header.
